// File: rtl/ja_traffic_light_multi_pkg.sv
// ja_traffic_pkg: shared types and default timing for the multi-approach
// traffic light controller.
//   tl_state_e   : FSM state encoding (also the value driven on the state port)
//   DEF_*        : default durations in ticks
//   next_phase() : round-robin successor of an approach index
package ja_traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED = 3'd0,
        GREEN   = 3'd1,
        YELLOW  = 3'd2,
        WALK    = 3'd3,
        FLASH   = 3'd4
    } tl_state_e;

    localparam int DEF_N_APP     = 2;
    localparam int DEF_GREEN_MIN = 4;
    localparam int DEF_GREEN_MAX = 8;
    localparam int DEF_YELLOW_T  = 2;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 3;
    localparam int DEF_FLASH_T   = 2;
    localparam int DEF_CNT_W     = 8;

    // Wraps to approach 0 after the last approach.
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input int n);
        if (int'(ph) >= n - 1) return 2'd0;
        return ph + 2'd1;
    endfunction

endpackage

// File: rtl/ja_traffic_light_multi_if.sv
// ja_traffic_light_multi_if: bundles the controller's demand inputs and lamp
// outputs.
//   master : pin wrapper / bench side, drives tick, veh_sense, ped_req, night
//   slave  : controller side, drives red, yellow, green, walk, phase, state
// Signalling: there is no valid/ready handshake. Every input is a level that
// the controller samples on each rising clk edge; it only acts on it when
// tick is 1. Every output is a register and changes only on clk or rst.
interface ja_traffic_light_multi_if #(
    parameter int N_APP = 2
);
    logic             tick;
    logic [N_APP-1:0] veh_sense;
    logic             ped_req;
    logic             night;
    logic [N_APP-1:0] red;
    logic [N_APP-1:0] yellow;
    logic [N_APP-1:0] green;
    logic             walk;
    logic [1:0]       phase;
    logic [2:0]       state;

    modport master (
        output tick, veh_sense, ped_req, night,
        input  red, yellow, green, walk, phase, state
    );

    modport slave (
        input  tick, veh_sense, ped_req, night,
        output red, yellow, green, walk, phase, state
    );
endinterface

// File: rtl/ja_traffic_light_multi_tick_timer.sv
// ja_tick_timer: down-counter that advances only on enabled ticks.
//   clk, rst : clock, asynchronous active-high reset (counter <= RST_VAL)
//   load/val : load val this cycle (wins over counting)
//   tick     : decrement enable; the counter stops at zero
//   done     : counter is zero on a tick cycle (last tick of the interval)
module ja_tick_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             tick,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt <= RST_VAL;
        else if (load)              cnt <= val;
        else if (tick && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign done = tick && (cnt == '0);
endmodule

// File: rtl/ja_traffic_light_multi.sv
// ja_traffic_light_multi: round-robin traffic light controller for N_APP
// approaches. It has a minimum and a maximum green, extends green for a
// vehicle that is waiting alone, latches a pedestrian walk phase and has a
// flashing-yellow night mode. All durations are counted in ticks.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave modport. Inputs are tick, veh_sense, ped_req and night.
//              Outputs are the lamps, phase (approach owning the current or
//              last green) and state (FSM code).
// All lamp outputs are registers. They are decoded from the next-state
// values, so no input reaches an output without passing through a flop.
module ja_traffic_light_multi
    import ja_traffic_pkg::*;
#(
    parameter int N_APP     = DEF_N_APP,
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T,
    parameter int FLASH_T   = DEF_FLASH_T,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    ja_traffic_light_multi_if.slave      bus
);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
    localparam logic [1:0]       PH_RST    = 2'(N_APP - 1);

    tl_state_e        state, st_n;
    logic [1:0]       phase, ph_n;
    logic             ped_pend, ped_n;
    logic             flash_ph, fl_n;
    logic [CNT_W-1:0] g_el, gel_n, e;
    logic             t_load, t_done;
    logic [CNT_W-1:0] t_val;
    logic [N_APP-1:0] ph_mask, oh_n;
    logic             hold;
    logic [N_APP-1:0] red_n, yel_n, grn_n;
    logic             walk_n;
    logic [N_APP-1:0] red_q, yel_q, grn_q;
    logic             walk_q;

    function automatic logic [N_APP-1:0] onehot(input logic [1:0] p);
        logic [N_APP-1:0] m;
        for (int i = 0; i < N_APP; i++) m[i] = (int'(p) == i);
        return m;
    endfunction

    // Green ends on the tick where the timer reaches zero, which is the
    // same tick as e == GREEN_MAX.
    ja_tick_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_LD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (t_load),
        .val  (t_val),
        .tick (bus.tick),
        .done (t_done)
    );

    always_comb begin
        st_n    = state;
        ph_n    = phase;
        fl_n    = flash_ph;
        gel_n   = g_el;
        t_load  = 1'b0;
        t_val   = ALLRED_LD;
        ph_mask = onehot(phase);
        e       = g_el + 1'b1;
        // Extend only while the owning approach is the sole demand and no walk is waiting.
        hold    = (|(bus.veh_sense & ph_mask)) && !(|(bus.veh_sense & ~ph_mask)) && !ped_pend;

        if (bus.tick) begin
            unique case (state)
                ALL_RED: if (t_done) begin
                    t_load = 1'b1;
                    if (bus.night) begin
                        st_n  = FLASH;
                        t_val = FLASH_LD;
                        fl_n  = 1'b1;          // night mode starts with yellow lit
                    end else if (ped_pend || bus.ped_req) begin
                        st_n  = WALK;
                        t_val = WALK_LD;
                    end else begin
                        st_n  = GREEN;
                        t_val = GREEN_LD;
                        ph_n  = next_phase(phase, N_APP);
                        gel_n = '0;
                    end
                end
                GREEN: begin
                    gel_n = e;
                    if (bus.night || t_done || (e >= CNT_W'(GREEN_MIN) && !hold)) begin
                        st_n   = YELLOW;
                        t_load = 1'b1;
                        t_val  = YELLOW_LD;
                    end
                end
                YELLOW, WALK: if (t_done) begin
                    st_n   = ALL_RED;
                    t_load = 1'b1;
                    t_val  = ALLRED_LD;
                end
                FLASH: begin
                    if (!bus.night) begin
                        st_n   = ALL_RED;
                        t_load = 1'b1;
                        t_val  = ALLRED_LD;
                    end else if (t_done) begin
                        fl_n   = ~flash_ph;
                        t_load = 1'b1;
                        t_val  = FLASH_LD;
                    end
                end
                default: begin
                    st_n   = ALL_RED;
                    t_load = 1'b1;
                    t_val  = ALLRED_LD;
                end
            endcase
        end

        // Walk entry consumes the request. Night mode ignores and discards requests.
        if (state == FLASH || st_n == FLASH || (st_n == WALK && state != WALK))
            ped_n = 1'b0;
        else
            ped_n = ped_pend || bus.ped_req;
    end

    always_comb begin
        red_n  = '1;
        yel_n  = '0;
        grn_n  = '0;
        walk_n = 1'b0;
        oh_n   = onehot(ph_n);
        case (st_n)
            GREEN:   begin grn_n = oh_n; red_n = ~oh_n; end
            YELLOW:  begin yel_n = oh_n; red_n = ~oh_n; end
            WALK:    walk_n = 1'b1;
            FLASH:   begin red_n = '0; yel_n = {N_APP{fl_n}}; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ALL_RED;
            phase    <= PH_RST;
            ped_pend <= 1'b0;
            flash_ph <= 1'b0;
            g_el     <= '0;
            red_q    <= '1;
            yel_q    <= '0;
            grn_q    <= '0;
            walk_q   <= 1'b0;
        end else begin
            state    <= st_n;
            phase    <= ph_n;
            ped_pend <= ped_n;
            flash_ph <= fl_n;
            g_el     <= gel_n;
            red_q    <= red_n;
            yel_q    <= yel_n;
            grn_q    <= grn_n;
            walk_q   <= walk_n;
        end
    end

    assign bus.red    = red_q;
    assign bus.yellow = yel_q;
    assign bus.green  = grn_q;
    assign bus.walk   = walk_q;
    assign bus.phase  = phase;
    assign bus.state  = state;
endmodule

// File: tb/tb_ja_traffic_light_multi.sv
// Bench for ja_traffic_light_multi with default parameters (N_APP=2).
// Each expected cycle is packed as {state, phase, red, yellow, green, walk}.
module tb_ja_traffic_light_multi;
    localparam int S_AR = 0, S_G = 1, S_Y = 2, S_W = 3, S_F = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ja_traffic_light_multi_if #(.N_APP(2)) bus ();
    ja_traffic_light_multi #(.N_APP(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [11:0] exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    int    tick_div = 1;
    string cur_tag = "init";

    function automatic logic [11:0] mk(input int st, input int ph, input bit fl);
        logic [1:0] oh, r, y, g;
        logic w;
        oh = (ph == 0) ? 2'b01 : 2'b10;
        r = 2'b11; y = 2'b00; g = 2'b00; w = 1'b0;
        case (st)
            S_G: begin g = oh; r = ~oh; end
            S_Y: begin y = oh; r = ~oh; end
            S_W: w = 1'b1;
            S_F: begin r = 2'b00; y = fl ? 2'b11 : 2'b00; end
            default: ;
        endcase
        return {3'(st), 2'(ph), r, y, g, w};
    endfunction

    task automatic push_seg(input int st, input int ph, input int n, input bit fl = 1'b0);
        repeat (n) exp_q.push_back(mk(st, ph, fl));
    endtask

    function automatic logic [11:0] observe();
        return {bus.state, bus.phase, bus.red, bus.yellow, bus.green, bus.walk};
    endfunction

    // Compare the current cycle, then drive tick for the next rising edge.
    task automatic step(input int n);
        logic [11:0] obs, ex;
        for (int i = 0; i < n; i++) begin
            obs = observe();
            checks++;
            if (exp_q.size() == 0) begin
                $error("FAIL %s underrun cyc %0d: observed %h expected none queued", cur_tag, cyc, obs);
            end else begin
                ex = exp_q.pop_front();
                assert (obs === ex) passes++;
                else $error("FAIL %s cyc %0d: observed %h expected %h", cur_tag, cyc, obs, ex);
            end
            bus.tick = (tick_div == 1) ? 1'b1 : ((cyc % tick_div) == tick_div - 1);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic drained();
        checks++;
        assert (exp_q.size() === 0) passes++;
        else $error("FAIL %s drain: observed %0d left expected 0", cur_tag, exp_q.size());
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [11:0] obs;
        rst = 1'b1;
        bus.tick = 1'b1;
        bus.veh_sense = 2'b00;
        bus.ped_req = 1'b0;
        bus.night = 1'b0;

        // Plain round robin with no demand.
        cur_tag = "t1_rr";
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 4); push_seg(S_Y, 0, 2); push_seg(S_AR, 0, 1);
        push_seg(S_G, 1, 4);  push_seg(S_Y, 1, 2); push_seg(S_AR, 1, 1); push_seg(S_G, 0, 4);
        do_reset(); step(19); drained();

        // Sole demand on approach 0 extends to GREEN_MAX.
        cur_tag = "t2_ext";
        bus.veh_sense = 2'b01;
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 8); push_seg(S_Y, 0, 2); push_seg(S_AR, 0, 1);
        push_seg(S_G, 1, 4);  push_seg(S_Y, 1, 2);
        do_reset(); step(18); drained();

        // Competing demand: no extension.
        cur_tag = "t2_both";
        bus.veh_sense = 2'b11;
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 4); push_seg(S_Y, 0, 2); push_seg(S_AR, 0, 1);
        push_seg(S_G, 1, 4);
        do_reset(); step(12); drained();

        // Pedestrian pulse in G0 cancels the extension and inserts a walk.
        cur_tag = "t3_ped";
        bus.veh_sense = 2'b01;
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 4); push_seg(S_Y, 0, 2); push_seg(S_AR, 0, 1);
        push_seg(S_W, 0, 3);  push_seg(S_AR, 0, 1); push_seg(S_G, 1, 4);
        do_reset(); step(2);
        bus.ped_req = 1'b1; step(1);
        bus.ped_req = 1'b0; step(13); drained();
        bus.veh_sense = 2'b00;

        // tick once every 3 clocks stretches every duration by three.
        cur_tag = "t4_tick3";
        tick_div = 3;
        push_seg(S_AR, 1, 3); push_seg(S_G, 0, 12); push_seg(S_Y, 0, 6); push_seg(S_AR, 0, 3);
        push_seg(S_G, 1, 12);
        do_reset(); step(36); drained();
        tick_div = 1;

        // Night mode: green cut short, flashing yellow, ped ignored, back to G1.
        cur_tag = "t5_night";
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 2); push_seg(S_Y, 0, 2); push_seg(S_AR, 0, 1);
        push_seg(S_F, 0, 2, 1'b1); push_seg(S_F, 0, 2, 1'b0); push_seg(S_F, 0, 2, 1'b1);
        push_seg(S_AR, 0, 1); push_seg(S_G, 1, 4); push_seg(S_Y, 1, 2);
        do_reset(); step(2);
        bus.night = 1'b1; step(7);
        bus.ped_req = 1'b1; step(1);
        bus.ped_req = 1'b0; step(1);
        bus.night = 1'b0; step(8); drained();

        // Asynchronous reset mid-yellow drops the pending walk.
        cur_tag = "t6_rst";
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 4); push_seg(S_Y, 0, 1);
        do_reset(); step(2);
        bus.ped_req = 1'b1; step(1);
        bus.ped_req = 1'b0; step(3);
        #2 rst = 1'b1;
        #1 obs = observe();
        checks++;
        assert (obs === mk(S_AR, 1, 1'b0)) passes++;
        else $error("FAIL t6_async_rst: observed %h expected %h", obs, mk(S_AR, 1, 1'b0));
        drained();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        push_seg(S_AR, 1, 1); push_seg(S_G, 0, 4); push_seg(S_Y, 0, 2); push_seg(S_AR, 0, 1);
        push_seg(S_G, 1, 4);
        step(12); drained();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
